fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch front end directly downstream of the next-PC select logic.
- Owns the architectural fetch PC and issues one-at-a-time requests to instruction memory over a valid/ready handshake.
- Buffers one fetched instruction for decode, together with its PC and PC+4; the PC+4 value feeds back as the sequential next-PC candidate.
- Accepts redirects (JAL/JALR/taken branch) and discards any in-flight stale fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction injected on a misaligned fetch (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- redirect_i  input  1  control-flow change resolved this cycle.
- redirect_pc_i  input  32  target PC (next-PC select output); used only when redirect_i=1.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts the request.
- imem_req_addr_o  output  32  fetch address; equals the fetch PC.
- imem_rsp_valid_i  input  1  read data valid; memory returns exactly one response per accepted request, any latency ≥1 cycle.
- imem_rsp_data_i  input  32  instruction word.
- inst_valid_o  output  1  decode buffer holds an instruction.
- inst_ready_i  input  1  decode accepts the instruction.
- inst_o  output  32  buffered instruction.
- inst_pc_o  output  32  PC of inst_o.
- inst_pc4_o  output  32  inst_pc_o+4, mod 2^32.
- fetch_misalign_o  output  1  present only with FETCH_MISALIGN_CHK_EN.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, state=REQ, buf_valid=0, inst_o/inst_pc_o=0, imem_req_valid_o=0, fetch_misalign_o=0.
- At most one outstanding request. The decode buffer is one entry, registered.
- imem_req_valid_o = (state==REQ) && !buf_valid. This output is registered-state derived, with no combinational path from any ready input.
- State REQ, on a handshake (valid && ready):
  - Capture req_pc=fetch_pc.
  - fetch_pc <= fetch_pc+4; 32'hFFFF_FFFC wraps to 0.
  - Go to WAIT.
- State WAIT:
  - rsp_valid && !redirect: load the buffer with {data, req_pc}, set buf_valid=1, go to REQ.
  - rsp_valid && redirect: discard the response, go to REQ.
  - !rsp_valid && redirect: go to DRAIN.
- State DRAIN: the next rsp_valid is discarded, then go to REQ. No request is issued while in DRAIN.
- Redirect, in any state:
  - fetch_pc <= redirect_pc_i, used as-is.
  - buf_valid <= 0; this takes priority over a buffer fill and over a decode handshake.
- Redirect in REQ in the same cycle as a request handshake: the accepted request is stale; go to DRAIN with fetch_pc=redirect_pc_i.
- Redirect in DRAIN: update fetch_pc, stay in DRAIN.
- Request stability: while valid && !ready, imem_req_addr_o holds steady. Exception: on a redirect cycle, the address changes the following cycle. The request may be withdrawn only on redirect.
- Decode handshake (inst_valid_o && inst_ready_i): buf_valid <= 0 next cycle. A refill may begin only after that, so sustained throughput is one instruction per 3 cycles with 1-cycle memory. This rate is intentional.
- A response received with no outstanding request is a protocol violation; ignore it and flag it with a bench assertion.
- Outputs inst_o, inst_pc_o and inst_pc4_o hold their value while inst_valid_o && !inst_ready_i.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Enabled: in REQ with buffer empty and fetch_pc[1:0]!=0:
  - No memory request is issued.
  - The buffer loads {NOP_INST, fetch_pc} with fetch_misalign_o=1 alongside inst_valid_o.
  - fetch_pc does not advance; fetching stalls until a redirect.
  - fetch_misalign_o clears with buf_valid.
- Disabled: port is absent; misaligned addresses are sent to memory unmodified.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency, decode ready=1 → addresses 0x0, 0x4, 0x8 in order; inst_pc4_o=0x4, 0x8, 0xC.
- Decode ready=0 for 5 cycles after the first instruction → inst_o/inst_pc_o held; no new request while buf_valid=1.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later with 0xDEADBEEF → response dropped; next request addr=0x100; the first delivered inst_pc_o is 0x100.
- Redirect to 0x200 in the same cycle as a response → buffer stays empty; next request addr=0x200.
- Redirect to 0x40 while the buffer holds pc 0x8 and decode ready=1 → no handshake for 0x8; the next delivered PC is 0x40.
- Fetch PC 0xFFFF_FFFC → next request addr 0x0. With FETCH_MISALIGN_CHK_EN, redirect to 0x102 → inst_o=0x13, fetch_misalign_o=1, no imem request.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response and decode-buffer handshake.
// With FETCH_MISALIGN_CHK_EN defined the bundle also carries fetch_misalign_o.
interface fetch_pc_unit_if;
    localparam int unsigned XLEN = 32;

    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic [XLEN-1:0] inst_pc4_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            fetch_misalign_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, inst_ready_i,
        output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
               inst_pc_o, inst_pc4_o, fetch_misalign_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, inst_ready_i,
        input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
               inst_pc_o, inst_pc4_o, fetch_misalign_o
    );
`else
    modport master (
        input  redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, inst_ready_i,
        output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
               inst_pc_o, inst_pc4_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, inst_ready_i,
        input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
               inst_pc_o, inst_pc4_o
    );
`endif
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the fetch PC, issues one imem request at a time and buffers one instruction.
// Optional FETCH_MISALIGN_CHK_EN: misaligned fetch PC injects NOP_INST with fetch_misalign_o and stalls.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_pc_unit_if.master  bus
);
    localparam int unsigned XLEN = 32;

    // S_HALT is only entered when the misalignment check is built in
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] inst_q, inst_pc_q, inst_pc4_q;
    logic            buf_load;
    logic [XLEN-1:0] buf_inst_d, buf_pc_d;
    logic            req_hs, decode_hs;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            mis_q, mis_d;
`endif

    assign req_hs    = req_valid_q & bus.imem_req_ready_i;
    assign decode_hs = buf_valid_q & bus.inst_ready_i;

    // Next-state, fetch PC and decode-buffer fill decisions
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_load    = 1'b0;
        buf_inst_d  = bus.imem_rsp_data_i;
        buf_pc_d    = req_pc_q;
        req_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        mis_d       = mis_q;
`endif

        unique case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = S_WAIT;
                end
`ifdef FETCH_MISALIGN_CHK_EN
                else if (!buf_valid_q && (fetch_pc_q[1:0] != 2'b00)) begin
                    buf_load   = 1'b1;
                    buf_inst_d = NOP_INST;
                    buf_pc_d   = fetch_pc_q;
                    mis_d      = 1'b1;
                    state_d    = S_HALT;
                end
`endif
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid_i) begin
                    state_d  = S_REQ;
                    buf_load = !bus.redirect_i;
                end else if (bus.redirect_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                if (bus.redirect_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (decode_hs) begin
            buf_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_d       = 1'b0;
`endif
        end
        if (buf_load) begin
            buf_valid_d = 1'b1;
        end

        // Redirect wins over fill and decode; a request accepted this cycle becomes stale
        if (bus.redirect_i) begin
            fetch_pc_d  = bus.redirect_pc_i;
            buf_valid_d = 1'b0;
            buf_load    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_d       = 1'b0;
`endif
            if (state_q == S_REQ) begin
                state_d = req_hs ? S_DRAIN : S_REQ;
            end
        end

        req_valid_d = (state_d == S_REQ) && !buf_valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
        req_valid_d = req_valid_d && (fetch_pc_d[1:0] == 2'b00);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            inst_pc4_q  <= XLEN'(4);
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            buf_valid_q <= buf_valid_d;
            if (buf_load) begin
                inst_q     <= buf_inst_d;
                inst_pc_q  <= buf_pc_d;
                inst_pc4_q <= buf_pc_d + XLEN'(4);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.fetch_misalign_o = mis_q;
`endif

    assign bus.imem_req_valid_o = req_valid_q;
    assign bus.imem_req_addr_o  = fetch_pc_q;
    assign bus.inst_valid_o     = buf_valid_q;
    assign bus.inst_o           = inst_q;
    assign bus.inst_pc_o        = inst_pc_q;
    assign bus.inst_pc4_o       = inst_pc4_q;

endmodule
